// File: rtl/mux_reg_n.sv
// Registered N:1 channel select with load-enable and flush.
// Modes: binary index (PRIO=0) or one-hot request with fixed priority and a one-entry pending buffer (PRIO=1).
module mux_reg_n #(
   parameter int               WIDTH   = 32,
   parameter int               N       = 4,
   parameter int               SW      = 2,
   parameter int               PRIO    = 0,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH*N-1:0] d,
   input  logic [SW-1:0]      sel,
   input  logic [N-1:0]       req,
   input  logic               en,
   input  logic               flush,
   output logic [WIDTH-1:0]   o,
   output logic               o_valid,
   output logic [SW-1:0]      o_src,
   output logic               multi_req
);

   // The channel table is padded to 2**SW entries, so any sel value indexes safely.
   localparam int NP = 1 << SW;

   logic [WIDTH-1:0] w_ch [NP];
   logic [SW-1:0]    w_win;
   logic             w_any;
   logic             w_multi;
   logic             w_sel_ok;

   logic [WIDTH-1:0] r_o;
   logic             r_valid;
   logic [SW-1:0]    r_src;
   logic             r_multi;
   logic             r_pend_valid;
   logic [SW-1:0]    r_pend_idx;
   logic [WIDTH-1:0] r_pend_data;

   for (genvar k = 0; k < NP; k++) begin : g_ch
      if (k < N) begin : g_real
         assign w_ch[k] = d[k*WIDTH +: WIDTH];
      end else begin : g_pad
         assign w_ch[k] = RST_VAL;
      end
   end

   // Lowest set request bit wins; scanning downward leaves the lowest index last.
   always_comb begin
      w_win = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[k]) begin
            w_win = SW'(k);
         end
      end
   end

   assign w_any    = |req;
   assign w_multi  = |(req & (req - N'(1)));
   assign w_sel_ok = (32'(sel) < N);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_o          <= RST_VAL;
         r_valid      <= 1'b0;
         r_src        <= '0;
         r_multi      <= 1'b0;
         r_pend_valid <= 1'b0;
         r_pend_idx   <= '0;
         r_pend_data  <= '0;
      end else if (flush) begin
         r_o          <= RST_VAL;
         r_valid      <= 1'b0;
         r_src        <= '0;
         r_pend_valid <= 1'b0;
      end else if (PRIO == 0) begin
         if (en) begin
            if (w_sel_ok) begin
               r_o     <= w_ch[sel];
               r_valid <= 1'b1;
               r_src   <= sel;
            end else begin
               r_o     <= RST_VAL;
               r_valid <= 1'b0;
               r_src   <= '0;
            end
         end
      end else begin
         if (en) begin
            if (r_pend_valid) begin
               // Deliver the buffered redirect; a same-cycle request skids into the buffer.
               r_o          <= r_pend_data;
               r_src        <= r_pend_idx;
               r_valid      <= 1'b1;
               r_pend_valid <= w_any;
               if (w_any) begin
                  r_pend_idx  <= w_win;
                  r_pend_data <= w_ch[w_win];
               end
            end else if (w_any) begin
               r_o     <= w_ch[w_win];
               r_src   <= w_win;
               r_valid <= 1'b1;
            end else begin
               r_valid <= 1'b0;
            end
            if (w_any && w_multi) begin
               r_multi <= 1'b1;
            end
         end else if (w_any && !r_pend_valid) begin
            r_pend_valid <= 1'b1;
            r_pend_idx   <= w_win;
            r_pend_data  <= w_ch[w_win];
            if (w_multi) begin
               r_multi <= 1'b1;
            end
         end
      end
   end

   assign o         = r_o;
   assign o_valid   = r_valid;
   assign o_src     = r_src;
   assign multi_req = r_multi;

endmodule

// File: tb/tb_mux_reg_n.sv
// Self-checking bench for mux_reg_n: binary mode (N=4 and N=3) and priority mode (N=4),
// all driven from shared inputs and compared every edge against a queue-based reference model.
module tb_mux_reg_n;
  localparam int W = 32;
  localparam logic [W-1:0] RV3 = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, flush;
  logic [1:0]   sel;
  logic [3:0]   req;
  logic [4*W-1:0] d;

  logic [W-1:0] o_a, o_b, o_c;
  logic         v_a, v_b, v_c;
  logic [1:0]   s_a, s_b, s_c;
  logic         m_a, m_b, m_c;

  mux_reg_n #(.WIDTH(W), .N(4), .SW(2), .PRIO(0), .RST_VAL('0)) u_bin4 (
    .clk(clk), .rst(rst), .d(d), .sel(sel), .req(req), .en(en), .flush(flush),
    .o(o_a), .o_valid(v_a), .o_src(s_a), .multi_req(m_a));

  mux_reg_n #(.WIDTH(W), .N(4), .SW(2), .PRIO(1), .RST_VAL('0)) u_pri4 (
    .clk(clk), .rst(rst), .d(d), .sel(sel), .req(req), .en(en), .flush(flush),
    .o(o_b), .o_valid(v_b), .o_src(s_b), .multi_req(m_b));

  mux_reg_n #(.WIDTH(W), .N(3), .SW(2), .PRIO(0), .RST_VAL(RV3)) u_bin3 (
    .clk(clk), .rst(rst), .d(d[3*W-1:0]), .sel(sel), .req(req[2:0]), .en(en), .flush(flush),
    .o(o_c), .o_valid(v_c), .o_src(s_c), .multi_req(m_c));

  // reference model state
  logic [W-1:0] e_o_a, e_o_b, e_o_c;
  logic         e_v_a, e_v_b, e_v_c, e_m_b;
  int           e_s_a, e_s_b, e_s_c;
  logic [W-1:0] pend_data_q[$];
  int           pend_idx_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] chan(input int k);
    return d[k*W +: W];
  endfunction

  function automatic int lowest_req();
    for (int k = 0; k < 4; k++) if (req[k]) return k;
    return -1;
  endfunction

  task automatic model_edge();
    int win;
    // binary N=4
    if (rst || flush) begin
      e_o_a = '0; e_v_a = 1'b0; e_s_a = 0;
    end else if (en) begin
      e_o_a = chan(int'(sel)); e_v_a = 1'b1; e_s_a = int'(sel);
    end
    // binary N=3, sel=3 is out of range
    if (rst || flush) begin
      e_o_c = RV3; e_v_c = 1'b0; e_s_c = 0;
    end else if (en) begin
      if (int'(sel) < 3) begin
        e_o_c = chan(int'(sel)); e_v_c = 1'b1; e_s_c = int'(sel);
      end else begin
        e_o_c = RV3; e_v_c = 1'b0; e_s_c = 0;
      end
    end
    // priority N=4
    win = lowest_req();
    if (rst) begin
      e_o_b = '0; e_v_b = 1'b0; e_s_b = 0; e_m_b = 1'b0;
      pend_data_q.delete(); pend_idx_q.delete();
    end else if (flush) begin
      e_o_b = '0; e_v_b = 1'b0; e_s_b = 0;
      pend_data_q.delete(); pend_idx_q.delete();
    end else if (en) begin
      if (pend_data_q.size() > 0) begin
        e_o_b = pend_data_q.pop_front(); e_s_b = pend_idx_q.pop_front(); e_v_b = 1'b1;
        if (win >= 0) begin
          pend_data_q.push_back(chan(win)); pend_idx_q.push_back(win);
        end
      end else if (win >= 0) begin
        e_o_b = chan(win); e_s_b = win; e_v_b = 1'b1;
      end else begin
        e_v_b = 1'b0;
      end
      if (win >= 0 && $countones(req) >= 2) e_m_b = 1'b1;
    end else if (win >= 0 && pend_data_q.size() == 0) begin
      pend_data_q.push_back(chan(win)); pend_idx_q.push_back(win);
      if ($countones(req) >= 2) e_m_b = 1'b1;
    end
  endtask

  task automatic compare_all();
    check_eq("bin4_o", o_a, e_o_a);
    check_eq("bin4_valid", 32'(v_a), 32'(e_v_a));
    check_eq("bin4_src", 32'(s_a), 32'(e_s_a));
    check_eq("bin4_multi", 32'(m_a), 32'd0);
    check_eq("pri4_o", o_b, e_o_b);
    check_eq("pri4_valid", 32'(v_b), 32'(e_v_b));
    check_eq("pri4_src", 32'(s_b), 32'(e_s_b));
    check_eq("pri4_multi", 32'(m_b), 32'(e_m_b));
    check_eq("bin3_o", o_c, e_o_c);
    check_eq("bin3_valid", 32'(v_c), 32'(e_v_c));
    check_eq("bin3_src", 32'(s_c), 32'(e_s_c));
    check_eq("bin3_multi", 32'(m_c), 32'd0);
  endtask

  // one clock edge: inputs are already stable, outputs sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_ch(input int k, input logic [W-1:0] v);
    d[k*W +: W] = v;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; sel = '0; req = '0;
    d = {32'h44, 32'h33, 32'h22, 32'h11};
    e_o_a = 'x; e_o_b = 'x; e_o_c = 'x;
    @(negedge clk);
    step();
    check_eq("rst_o_bin3", o_c, RV3);
    check_eq("rst_valid_pri", 32'(v_b), 32'd0);

    // binary select, then stall, then flush
    rst = 1'b0; en = 1'b1; sel = 2'd2; step();
    check_eq("sel2_o", o_a, 32'h33);
    check_eq("sel2_src", 32'(s_a), 32'd2);
    sel = 2'd0; step();
    check_eq("sel0_o", o_a, 32'h11);
    check_eq("sel0_valid", 32'(v_a), 32'd1);
    sel = 2'd2; step();
    en = 1'b0; sel = 2'd1;
    repeat (3) step();
    check_eq("stall_o", o_a, 32'h33);
    check_eq("stall_src", 32'(s_a), 32'd2);
    flush = 1'b1; en = 1'b1; step();
    check_eq("flush_o", o_a, 32'h0);
    check_eq("flush_valid", 32'(v_a), 32'd0);
    flush = 1'b0;

    // out-of-range sel on N=3 instance
    sel = 2'd3; step();
    check_eq("oor_o_bin3", o_c, RV3);
    check_eq("oor_valid_bin3", 32'(v_c), 32'd0);

    // multi-request capture, sticky until rst
    sel = 2'd0; req = 4'b0110; step();
    check_eq("multi_o", o_b, 32'h22);
    check_eq("multi_src", 32'(s_b), 32'd1);
    check_eq("multi_set", 32'(m_b), 32'd1);
    req = 4'b0000; step();
    check_eq("multi_hold_idle", 32'(m_b), 32'd1);
    flush = 1'b1; step();
    check_eq("multi_hold_flush", 32'(m_b), 32'd1);
    flush = 1'b0; rst = 1'b1; step();
    check_eq("multi_clr_rst", 32'(m_b), 32'd0);
    rst = 1'b0;

    // first request wins while stalled
    en = 1'b0; set_ch(3, 32'hAA); req = 4'b1000; step();
    req = 4'b0001; step();
    en = 1'b1; req = 4'b0000; step();
    check_eq("pend_o", o_b, 32'hAA);
    check_eq("pend_src", 32'(s_b), 32'd3);
    step();
    check_eq("pend_empty_valid", 32'(v_b), 32'd0);

    // skid: buffer delivered while a new request refills it
    en = 1'b0; set_ch(2, 32'hCC); req = 4'b0100; step();
    en = 1'b1; set_ch(0, 32'h55); req = 4'b0001; step();
    check_eq("skid_o1", o_b, 32'hCC);
    set_ch(0, 32'h99); req = 4'b0000; step();
    check_eq("skid_o2", o_b, 32'h55);
    check_eq("skid_src2", 32'(s_b), 32'd0);

    // reset while stalled with a full buffer
    en = 1'b0; req = 4'b0010; step();
    rst = 1'b1; req = 4'b0000; step();
    check_eq("rst_stall_o", o_b, 32'h0);
    rst = 1'b0; en = 1'b1; step();
    check_eq("rst_pend_lost", 32'(v_b), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 19) == 0);
      en    = ($urandom_range(0, 3) != 0);
      sel   = 2'($urandom_range(0, 3));
      req   = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      d     = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
